// File: rtl/y86_memstore.sv
// rtl/y86_memstore.sv - 32-bit little-endian store into a 256 x 64-bit big-endian-byte RAM
// Optional macro Y86_MEMSTORE_ERR_EN rejects stores with addr[31:11] != 0.
module y86_memstore (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  ram_addr,
  input  logic [63:0] ram_rdata,
  output logic [63:0] ram_wdata,
  output logic        ram_we
);

  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, DONE} state_t;

  state_t      state, state_d;
  logic [10:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  w0, w1;
  logic [2:0]  off;
  logic        accept;
  logic        addr_bad;

  assign w0     = addr_q[10:3];
  assign w1     = w0 + 8'd1;
  assign off    = addr_q[2:0];
  assign accept = (state == IDLE) && req;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

`ifdef Y86_MEMSTORE_ERR_EN
  logic err_q;

  assign addr_bad = |addr[31:11];
  assign err      = done && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= addr_bad;
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^addr[31:11];
  assign addr_bad  = 1'b0;
  assign err       = 1'b0;
`endif

  // Byte k of a RAM word sits at [63-8k -: 8]; wdata byte i goes to memory byte addr+i.
  // The second pass places the tail bytes (8-off)..3 at bytes 0.. of the next word.
  function automatic logic [63:0] merge_word(input logic [63:0] old_word,
                                             input logic [31:0] data,
                                             input logic [2:0]  o,
                                             input logic        second);
    logic [63:0] w;
    int          src;
    w = old_word;
    for (int k = 0; k < 8; k++) begin
      src = second ? (k + 8 - int'(o)) : (k - int'(o));
      if (src >= 0 && src < 4) begin
        w[63-8*k -: 8] = data[8*src +: 8];
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        addr_q  <= addr[10:0];
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ram_addr  = 8'd0;
    ram_we    = 1'b0;
    ram_wdata = 64'd0;
    case (state)
      IDLE: if (req) state_d = addr_bad ? DONE : RD0;
      RD0: begin
        ram_addr = w0;
        state_d  = WR0;
      end
      WR0: begin
        ram_addr  = w0;
        ram_we    = 1'b1;
        ram_wdata = merge_word(ram_rdata, wdata_q, off, 1'b0);
        state_d   = (off > 3'd4) ? RD1 : DONE;
      end
      RD1: begin
        ram_addr = w1;
        state_d  = WR1;
      end
      WR1: begin
        ram_addr  = w1;
        ram_we    = 1'b1;
        ram_wdata = merge_word(ram_rdata, wdata_q, off, 1'b1);
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_y86_memstore.sv
// tb/tb_y86_memstore.sv - self-checking bench for y86_memstore with a behavioural RAM and byte-level model
module tb_y86_memstore;

  logic        clk = 1'b0;
  logic        reset, req;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [7:0]  ram_addr;
  logic [63:0] ram_rdata, ram_wdata;
  logic        ram_we;

  always #5 clk = ~clk;

  y86_memstore dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  logic [63:0] mem     [0:255];
  logic [63:0] ref_mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [63:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [63:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Memory as a flat byte array: byte address b lives in word b>>3 at byte lane b&7.
  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    logic [10:0] b;
    int          k;
    for (int i = 0; i < 4; i++) begin
      b = a[10:0] + 11'(i);
      k = int'(b[2:0]);
      ref_mem[b[10:3]][63-8*k -: 8] = d[8*i +: 8];
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wes, output bit err_at_done,
                          output bit wd_ok, output bit tmo);
    @(negedge clk);
    addr  = a;
    wdata = d;
    req   = 1'b1;
    @(negedge clk);
    lat = 0; wes = 0; tmo = 1'b1; wd_ok = 1'b1; err_at_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      addr  = $urandom;
      wdata = $urandom;
      if (ram_we) wes++;
      if (!ram_we && ram_wdata != 64'd0) wd_ok = 1'b0;
      if (done) begin
        lat = c; err_at_done = err; tmo = 1'b0;
        req = 1'b0;
        break;
      end
      req = 1'b1;
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [63:0] init0, init1, exp0, exp1;
    int          lat, wes;
  } vec_t;

  vec_t        vt [6];
  int          lat, wes, bad;
  bit          e, wd_ok, tmo;
  logic [7:0]  w0;
  logic [31:0] ra, rd;
  logic [63:0] r, saved;

  initial begin
    vt[0] = '{32'h000, 32'hAABBCCDD, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'hDDCCBBAA04050607, 64'h08090A0B0C0D0E0F, 3, 1};
    vt[1] = '{32'h002, 32'hAABBCCDD, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h0001DDCCBBAA0607, 64'h08090A0B0C0D0E0F, 3, 1};
    vt[2] = '{32'h00E, 32'hAABBCCDD, 64'h08090A0B0C0D0E0F, 64'h1011121314151617,
              64'h08090A0B0C0DDDCC, 64'hBBAA121314151617, 5, 2};
    vt[3] = '{32'h7FF, 32'h11223344, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h0001020304050644, 64'h3322110B0C0D0E0F, 5, 2};
    vt[4] = '{32'h004, 32'hAABBCCDD, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h00010203DDCCBBAA, 64'h08090A0B0C0D0E0F, 3, 1};
    vt[5] = '{32'h005, 32'hAABBCCDD, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h0001020304DDCCBB, 64'hAA090A0B0C0D0E0F, 5, 2};

    reset = 1'b1; req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    pl_en = 1'b0; pl_idx = 8'd0; pl_val = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      w0 = vt[i].a[10:3];
      preload(w0, vt[i].init0);
      preload(w0 + 8'd1, vt[i].init1);
      do_store(vt[i].a, vt[i].d, lat, wes, e, wd_ok, tmo);
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_we_pulses", i), wes, vt[i].wes);
      chk($sformatf("v%0d_wdata_zero", i), wd_ok, 1);
      chk($sformatf("v%0d_word0", i), mem[w0], vt[i].exp0);
      chk($sformatf("v%0d_word1", i), mem[w0 + 8'd1], vt[i].exp1);
    end

    for (int i = 0; i < 256; i++) begin
      r = {$urandom, $urandom};
      ref_mem[i] = r;
      preload(8'(i), r);
    end
    for (int n = 0; n < 40; n++) begin
`ifdef Y86_MEMSTORE_ERR_EN
      ra = $urandom & 32'h7FF;
`else
      ra = $urandom;
`endif
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_store(ra, rd, lat, wes, e, wd_ok, tmo);
      ref_store(ra, rd);
      chk($sformatf("rnd%0d_latency a=%h", n, ra), lat, (ra[2:0] > 3'd4) ? 5 : 3);
      chk($sformatf("rnd%0d_err", n), e, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk($sformatf("rnd%0d_ram_words_wrong a=%h", n, ra), bad, 0);
    end

    preload(8'd1, 64'h08090A0B0C0D0E0F);
    preload(8'd2, 64'h1011121314151617);
    @(negedge clk);
    addr = 32'h0E; wdata = 32'hAABBCCDD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd1_addr", ram_addr, 8'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_we", ram_we, 0);
    chk("rstmid_addr", ram_addr, 0);
    repeat (4) @(negedge clk);
    chk("rstmid_word1", mem[1], 64'h08090A0B0C0DDDCC);
    chk("rstmid_word2", mem[2], 64'h1011121314151617);

    saved = mem[0];
    @(negedge clk);
    reset = 1'b1; req = 1'b1; addr = 32'h0; wdata = 32'h12345678;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    chk("rst_prio_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("rst_prio_word0", mem[0], saved);

`ifdef Y86_MEMSTORE_ERR_EN
    do_store(32'h800, 32'hAABBCCDD, lat, wes, e, wd_ok, tmo);
    chk("err_timeout", tmo, 0);
    chk("err_latency", lat, 1);
    chk("err_we_pulses", wes, 0);
    chk("err_flag", e, 1);
    chk("err_word0", mem[0], saved);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/y86_memstore.md
Y86_MEMSTORE -- requirements
Module: y86_memstore

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req, input, 1 bit: store request, sampled only in IDLE.
REQ-004 SHALL have port addr, input, 32 bits: byte address of the store.
REQ-005 SHALL have port wdata, input, 32 bits: store value, little-endian, so byte at addr+i is wdata[8i+7:8i].
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-008 SHALL have port err, output, 1 bit: request-rejected pulse, coincident with done.
REQ-009 SHALL have port ram_addr, output, 8 bits: word index into a 256 x 64-bit RAM.
REQ-010 SHALL have port ram_rdata, input, 64 bits: RAM read data, valid the cycle after ram_addr is presented.
REQ-011 SHALL have port ram_wdata, output, 64 bits: merged word to write.
REQ-012 SHALL have port ram_we, output, 1 bit: RAM write enable; RAM writes ram_wdata at ram_addr on the clk edge.

Function
REQ-013 SHALL use word byte order in which byte k (k = 0..7) of a word occupies bits [63-8k : 56-8k], i.e. byte 0 is the MSB byte.
REQ-014 SHALL latch addr and wdata when req=1 in IDLE; input changes while busy SHALL have no effect.
REQ-015 SHALL ignore req while busy=1; ignored requests are not queued.
REQ-016 SHALL compute word w0 = addr[10:3], offset o = addr[2:0], and w1 = w0+1 modulo 256, so 0xFF wraps to 0x00.
REQ-017 SHALL implement FSM states IDLE, RD0, WR0, RD1, WR1, DONE.
REQ-018 SHALL follow transitions IDLE->RD0 on req, RD0->WR0, WR0->DONE if o<=4, WR0->RD1 if o>4, RD1->WR1, WR1->DONE, DONE->IDLE.
REQ-019 SHALL drive ram_addr = w0 in RD0 and WR0, and ram_addr = w1 in RD1 and WR1.
REQ-020 SHALL assert ram_we only in WR0 and WR1.
REQ-021 SHALL in WR0 drive ram_wdata as ram_rdata with bytes o..min(o+3,7) replaced by wdata bytes 0.. in ascending order, all other bytes unchanged.
REQ-022 SHALL in WR1 drive ram_wdata as ram_rdata with bytes 0..(o-5) replaced by the remaining wdata bytes (8-o)..3, all other bytes unchanged.
REQ-023 SHALL assert done for exactly one cycle, in DONE.
REQ-024 SHALL give latency, measured from the accepting edge to the done cycle, of 3 cycles for o<=4 and 5 cycles for o>4.
REQ-025 SHALL allow a new req to be accepted in the IDLE cycle that directly follows DONE (back-to-back, no extra idle cycles).
REQ-026 SHALL drive ram_wdata to 0 whenever ram_we=0.

Reset
REQ-027 SHALL on reset=1 at a clk edge force state IDLE, with busy=0, done=0, err=0, ram_we=0, ram_addr=0, and clear the latched addr/wdata.
REQ-028 SHALL on reset mid-operation abort the store: a WR0 already committed remains in RAM, and no WR1 is issued.
REQ-029 SHALL give reset priority over a simultaneous req.

Configuration
REQ-030 SHALL recognise macro Y86_MEMSTORE_ERR_EN.
REQ-031 SHALL with Y86_MEMSTORE_ERR_EN defined, on acceptance with addr[31:11] != 0, go IDLE->DONE directly, issue no RAM access, and assert err with done.
REQ-032 SHALL without Y86_MEMSTORE_ERR_EN, ignore addr[31:11] and tie err to 0.

Verification
REQ-033 SHALL cover an aligned store: word0 = 0x0001020304050607, addr=0x00, wdata=0xAABBCCDD -> word0 = 0xDDCCBBAA04050607, done 3 cycles after accept, one ram_we pulse.
REQ-034 SHALL cover a single-word unaligned store: word0 = 0x0001020304050607, addr=0x02, wdata=0xAABBCCDD -> word0 = 0x0001DDCCBBAA0607.
REQ-035 SHALL cover a spanning store: word1 = 0x08090A0B0C0D0E0F, word2 = 0x1011121314151617, addr=0x0E, wdata=0xAABBCCDD -> word1 = 0x08090A0B0C0DDDCC, word2 = 0xBBAA121314151617, done 5 cycles after accept, two ram_we pulses.
REQ-036 SHALL cover wrap-around: addr=0x7FF, wdata=0x11223344 -> word 0xFF byte 7 = 0x44, word 0x00 bytes 0..2 = 0x33,0x22,0x11, no other bytes changed.
REQ-037 SHALL cover reset in RD1 during the 0x0E store -> word1 updated, word2 unchanged, busy=0 the next cycle.
REQ-038 SHALL cover, with Y86_MEMSTORE_ERR_EN defined, addr=0x800 -> no ram_we, err=1 and done=1 in the same cycle, 1 cycle after accept.
